// File: rtl/fetch_line_stage.sv
// fetch_line_stage: line-buffered instruction fetch, one insn/cycle to decode, stalls for redirect after control flow.
// Define FETCH_PERF_CNT_EN to add saturating perf counters; opcode is insn[31:26].
module fetch_line_stage #(
   parameter int CORE_ID = 0,
   parameter int LINE_WORDS = 2,
   parameter int ADDR_W = 64,
   parameter int MASK_W = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [ADDR_W-1:0]        mem_req_addr,
   output logic [15:0]              mem_req_id,
   input  logic                     mem_rsp_valid,
   input  logic [32*LINE_WORDS-1:0] mem_rsp_data,
   input  logic                     mem_rsp_err,
   output logic                     dec_valid,
   input  logic                     dec_ready,
   output logic [ADDR_W-1:0]        dec_pc,
   output logic [31:0]              dec_insn,
   output logic [MASK_W-1:0]        dec_mask,
   input  logic                     redir_valid,
   input  logic [ADDR_W-1:0]        redir_pc,
   input  logic [MASK_W-1:0]        redir_mask,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]              perf_wait_cycles,
   output logic [31:0]              perf_insn_count,
   output logic [31:0]              perf_redir_stall,
`endif
   output logic                     fetch_err
);
   localparam int LB = $clog2(LINE_WORDS * 4);
   localparam int TAG_W = ADDR_W - LB;
   localparam int IW = LINE_WORDS > 1 ? $clog2(LINE_WORDS) : 1;
   localparam logic [7:0] COMPONENT_TYPE_FETCH = 8'h01;
   localparam logic [5:0] OP_HALT = 6'h3F;
   localparam logic [5:0] OP_LOAD_RESTORE_PC = 6'h20;
   localparam logic [2:0] OP_JMP_GRP = 3'b010;

   typedef enum logic [2:0] {RESET_ST, CHECK, REQ, WAIT_RSP, EMIT, WAIT_REDIR, HALT_ST} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [MASK_W-1:0] mask_q, mask_d;
   logic [31:0]       line_q [LINE_WORDS];
   logic [31:0]       line_d [LINE_WORDS];
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              line_valid_q, line_valid_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   pc_inc;
   logic [IW-1:0]     widx;
   logic [31:0]       insn;

   // JMP_* occupy opcodes 0x10..0x17
   function automatic logic changes_control_flow(input logic [31:0] i);
      return i[31:26] == OP_HALT || i[31:26] == OP_LOAD_RESTORE_PC || i[31:29] == OP_JMP_GRP;
   endfunction

   assign pc_inc = {1'b0, pc_q} + (ADDR_W+1)'(4);
   assign widx = LINE_WORDS > 1 ? IW'(pc_q >> 2) : '0;
   assign insn = line_q[widx];

   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      mask_d = mask_q;
      line_d = line_q;
      tag_d = tag_q;
      line_valid_d = line_valid_q;
      err_d = err_q;
      mem_req_valid = 1'b0;
      dec_valid = 1'b0;
      case (state_q)
         RESET_ST: state_d = CHECK;
         CHECK: state_d = (line_valid_q && pc_q[ADDR_W-1:LB] == tag_q) ? EMIT : REQ;
         REQ: begin
            mem_req_valid = 1'b1;
            state_d = mem_req_ready ? WAIT_RSP : REQ;
         end
         WAIT_RSP: if (mem_rsp_valid) begin
            if (mem_rsp_err) begin
               err_d = 1'b1;
               state_d = HALT_ST;
            end else begin
               for (int k = 0; k < LINE_WORDS; k++) line_d[k] = mem_rsp_data[32*k +: 32];
               tag_d = pc_q[ADDR_W-1:LB];
               line_valid_d = 1'b1;
               state_d = EMIT;
            end
         end
         EMIT: begin
            dec_valid = 1'b1;
            if (dec_ready && changes_control_flow(insn)) state_d = WAIT_REDIR;
            else if (dec_ready) begin
               pc_d = pc_inc[ADDR_W-1:0];
               state_d = (!pc_inc[ADDR_W] && pc_inc[ADDR_W-1:LB] == tag_q) ? EMIT : CHECK;
            end
         end
         WAIT_REDIR: if (redir_valid) begin
            pc_d = redir_pc;
            mask_d = redir_mask;
            err_d = |redir_pc[1:0];
            state_d = |redir_pc[1:0] ? HALT_ST : CHECK;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RESET_ST;
         pc_q <= RESET_PC;
         mask_q <= '1;
         line_q <= '{default: '0};
         tag_q <= '0;
         line_valid_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         mask_q <= mask_d;
         line_q <= line_d;
         tag_q <= tag_d;
         line_valid_q <= line_valid_d;
         err_q <= err_d;
      end
   end

   assign mem_req_addr = mem_req_valid ? {pc_q[ADDR_W-1:LB], {LB{1'b0}}} : '0;
   assign mem_req_id = mem_req_valid ? {8'(CORE_ID), COMPONENT_TYPE_FETCH} : '0;
   assign dec_pc = dec_valid ? pc_q : '0;
   assign dec_insn = dec_valid ? insn : '0;
   assign dec_mask = dec_valid ? mask_q : '0;
   assign fetch_err = err_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_wait_q, perf_wait_d, perf_insn_q, perf_insn_d, perf_redir_q, perf_redir_d;

   always_comb begin
      perf_wait_d = (state_q == WAIT_RSP && !mem_rsp_valid && ~&perf_wait_q) ? perf_wait_q + 32'd1 : perf_wait_q;
      perf_insn_d = (dec_valid && dec_ready && ~&perf_insn_q) ? perf_insn_q + 32'd1 : perf_insn_q;
      perf_redir_d = (state_q == WAIT_REDIR && ~&perf_redir_q) ? perf_redir_q + 32'd1 : perf_redir_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_wait_q <= '0;
         perf_insn_q <= '0;
         perf_redir_q <= '0;
      end else begin
         perf_wait_q <= perf_wait_d;
         perf_insn_q <= perf_insn_d;
         perf_redir_q <= perf_redir_d;
      end
   end

   assign perf_wait_cycles = perf_wait_q;
   assign perf_insn_count = perf_insn_q;
   assign perf_redir_stall = perf_redir_q;
`endif
endmodule
